// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: drives the PC into a 1-cycle synchronous-read memory, tags the
// in-flight read, and buffers returned words in a 2-entry FIFO. Optional counters: IFETCH_PERF_EN.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] last_pc_q, last_pc_d;
  logic        misalign_q, misalign_d;

  logic        pop;
  logic        issue;
  logic [1:0]  occupancy;

  assign mem_addr     = fetch_pc_q;
  assign out_valid    = (count_q != 2'd0);
  assign out_instr    = out_valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
  assign out_pc       = out_valid ? fifo_pc_q[rd_ptr_q] : last_pc_q;
  assign misalign_err = misalign_q;

  assign pop       = out_valid & out_ready;
  assign occupancy = count_q + {1'b0, inflight_q};
  // Slot reserved for the in-flight word, so the FIFO can never overflow.
  assign issue     = (occupancy <= 2'd1) || ((occupancy == 2'd2) && pop);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    last_pc_d     = out_valid ? fifo_pc_q[rd_ptr_q] : last_pc_q;
    misalign_d    = redirect_valid && (redirect_pc[1:0] != 2'b00);

    if (redirect_valid) begin
      // Flush: the response returning next cycle is untagged and therefore dropped.
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      inflight_d = 1'b0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      if (inflight_q) begin
        fifo_instr_d[wr_ptr_q] = mem_rdata;
        fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
        wr_ptr_d               = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end else begin
        inflight_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q      <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_pc_q   <= 32'd0;
      count_q         <= 2'd0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      fifo_instr_q[0] <= NOP_INSTR;
      fifo_instr_q[1] <= NOP_INSTR;
      fifo_pc_q[0]    <= 32'd0;
      fifo_pc_q[1]    <= 32'd0;
      last_pc_q       <= 32'd0;
      misalign_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc_q     <= fifo_pc_d;
      last_pc_q     <= last_pc_d;
      misalign_q    <= misalign_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (pop) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (out_valid && !out_ready) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed and random steps compared each cycle against a queue-based
// model of the fetch pipeline. Define IFETCH_PERF_EN to also check the counters.
module tb_ifetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  ifetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  logic [31:0] mem_init [16] = '{
    32'h0094_0333, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193,
    32'h0040_0213, 32'h0050_0293, 32'hFE64_2023, 32'h0070_0393,
    32'h1234_5037, 32'h0090_0493, 32'h00A0_0513, 32'h00B0_0593,
    32'h00C0_0613, 32'h00D0_0693, 32'h00E0_0713, 32'h00F0_0793
  };

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a < 32'h40) return mem_init[a[5:2]];
    return NOP_INSTR;
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) mem_rdata <= memf(mem_addr);

  int errors = 0;
  int checks = 0;

  logic [31:0] q_pc [$];
  logic [31:0] q_ins [$];
  int          m_infl;
  logic [31:0] m_ipc;
  logic [31:0] m_fpc;
  logic [31:0] m_last;
  logic        m_mis;
  logic [31:0] m_pf;
  logic [31:0] m_ps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc,
                            input logic rdy);
    int  occ;
    bit  valid;
    bit  pop;
    bit  issue;
    if (r) begin
      q_pc.delete();
      q_ins.delete();
      m_infl = 0;
      m_ipc  = 32'd0;
      m_fpc  = RESET_PC;
      m_last = 32'd0;
      m_mis  = 1'b0;
      m_pf   = 32'd0;
      m_ps   = 32'd0;
    end else begin
      valid = (q_pc.size() != 0);
      pop   = valid && rdy;
      if (valid) m_last = q_pc[0];
      if (pop) m_pf = m_pf + 32'd1;
      if (valid && !rdy) m_ps = m_ps + 32'd1;
      m_mis = rv && (rpc[1:0] != 2'b00);
      if (rv) begin
        q_pc.delete();
        q_ins.delete();
        m_infl = 0;
        m_fpc  = {rpc[31:2], 2'b00};
      end else begin
        occ   = q_pc.size() + m_infl;
        issue = (occ <= 1) || (occ == 2 && pop);
        if (pop) begin
          void'(q_pc.pop_front());
          void'(q_ins.pop_front());
        end
        if (m_infl != 0) begin
          q_pc.push_back(m_ipc);
          q_ins.push_back(memf(m_ipc));
        end
        if (issue) begin
          m_infl = 1;
          m_ipc  = m_fpc;
          m_fpc  = m_fpc + 32'd4;
        end else begin
          m_infl = 0;
        end
      end
    end
  endtask

  // Check outputs away from the edge, then drive inputs for the next edge.
  task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit v;
    @(negedge clk);
    v = (q_pc.size() != 0);
    check("out_valid", {31'd0, out_valid}, {31'd0, v});
    check("out_instr", out_instr, v ? q_ins[0] : NOP_INSTR);
    check("out_pc", out_pc, v ? q_pc[0] : m_last);
    check("mem_addr", mem_addr, m_fpc);
    check("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
`ifdef IFETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_pf);
    check("perf_stall", perf_stall, m_ps);
`endif
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    model_step(r, rv, rpc, rdy);
  endtask

  initial begin
    logic        r;
    logic        rv;
    logic        rdy;
    logic [31:0] rpc;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b0;
    model_step(1'b1, 1'b0, 32'd0, 1'b0);

    // Reset state, then streaming with decode always ready.
    step(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Stall right after the first word of a fresh stream.
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect while buffered, then a misaligned redirect.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 32'h20, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 32'h1A, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Back-to-back redirects, then a mid-stream reset.
    step(1'b0, 1'b1, 32'h08, 1'b1);
    step(1'b0, 1'b1, 32'h2C, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Run past the populated region and across the address wrap.
    step(1'b0, 1'b1, 32'h38, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_FFF5, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, i[0]);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else rpc = 32'($urandom_range(0, 80));
      step(r, rv, rpc, rdy);
    end
    step(1'b0, 1'b0, 32'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
